local_window_gen: RTL

LOCAL_WINDOW_GEN -- requirements
Module: local_window_gen

---
 rtl/bf_pkg.sv | 12 +
 rtl/line_buffer.sv | 40 ++++
 rtl/local_window_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared pixel/window definitions for the local window generator and range kernel.
package bf_pkg;
  localparam int PIX_W    = 10;
  localparam int WIN_SIZE = 7;
  localparam int WIN_NUM  = WIN_SIZE * WIN_SIZE;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int win_idx(input int dr, input int dc);
    return dr * WIN_SIZE + dc;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay: output is the pixel written DEPTH accepted pixels earlier.
module line_buffer
  import bf_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  pixel_t din_i,
  output pixel_t dout_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Read-before-write at the same slot yields exactly DEPTH cycles of delay.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end
endmodule

// File: rtl/local_window_gen.sv
// Raster-scan 7x7 neighbourhood generator: six line delays feed a shifting window,
// which is registered to the output only at interior (non-border) positions.
module local_window_gen
  import bf_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  pixel_t               pixel_in,
  input  logic                 pixel_valid,
  output pixel_t [WIN_NUM-1:0] local_window,
  output logic                 local_window_valid,
  output logic                 frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          emit;
  logic          last_pix;

  pixel_t lb_in  [WIN_SIZE-1];
  pixel_t lb_out [WIN_SIZE-1];
  pixel_t tap    [WIN_SIZE];

  pixel_t [WIN_NUM-1:0] win_q, win_d;
  pixel_t [WIN_NUM-1:0] win_out_q;
  logic                 win_vld_q;
  logic                 frame_done_q;

  // lb_out[k] carries row (row-6+k); the chain is fed from the live pixel at the top.
  always_comb begin
    for (int k = 0; k < WIN_SIZE - 1; k++) begin
      lb_in[k] = (k == WIN_SIZE - 2) ? pixel_in : lb_out[k+1];
      tap[k]   = lb_out[k];
    end
    tap[WIN_SIZE-1] = pixel_in;
  end

  for (genvar g = 0; g < WIN_SIZE - 1; g++) begin : g_lb
    line_buffer #(.DEPTH(IMG_W)) u_lb (
      .clk    (clk),
      .rst    (rst),
      .en_i   (pixel_valid),
      .din_i  (lb_in[g]),
      .dout_o (lb_out[g])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int dr = 0; dr < WIN_SIZE; dr++) begin
      for (int dc = 0; dc < WIN_SIZE - 1; dc++) begin
        win_d[win_idx(dr, dc)] = win_q[win_idx(dr, dc + 1)];
      end
      win_d[win_idx(dr, WIN_SIZE - 1)] = tap[dr];
    end
  end

  always_comb begin
    last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    emit     = pixel_valid && (col_q >= COL_MIN) && (row_q >= ROW_MIN);
    col_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    row_d    = row_q;
    if (col_q == COL_LAST) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      win_q <= win_d;
    end
  end

  // Border gating guarantees every captured column belongs to the current line and frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      win_out_q    <= '0;
    end else begin
      win_vld_q    <= emit;
      frame_done_q <= pixel_valid && last_pix;
      if (pixel_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (emit) begin
        win_out_q <= win_d;
      end
    end
  end

  assign local_window       = win_out_q;
  assign local_window_valid = win_vld_q;
  assign frame_done         = frame_done_q;
endmodule
